// File: rtl/adc_speed_sampler.sv
// Paced ADC sequencer: start pulse, eoc wait with timeout, settled read, then a 2^AVG_LOG2 sample average.
// Optional macro ADC_SPEED_DEADZONE_EN forces averages below 16 to 0 and above 239 to 255.
module adc_speed_sampler #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int START_CYCLES  = 4,
  parameter int TIMEOUT       = 20000,
  parameter int READ_CYCLES   = 3,
  parameter int AVG_LOG2      = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_eoc,
  input  logic [7:0] i_adc_data,
  output logic       o_adc_start,
  output logic       o_adc_oe,
  output logic [7:0] o_move_speed,
  output logic       o_speed_valid,
  output logic       o_busy,
  output logic       o_timeout_err
);

  localparam int PER_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CNT_MAX_A = (START_CYCLES > READ_CYCLES) ? START_CYCLES : READ_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT > CNT_MAX_A) ? TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int ACC_W     = 8 + AVG_LOG2;
  localparam int NUM_W     = AVG_LOG2 + 1;

  localparam logic [PER_W-1:0] PER_LAST     = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(READ_CYCLES - 1);
  localparam logic [NUM_W-1:0] NUM_LAST     = NUM_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_EOC,
    S_READ,
    S_ACCUM
  } state_t;

  state_t           r_state;
  logic [PER_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [NUM_W-1:0] r_num;
  logic [7:0]       r_sample;
  logic [7:0]       r_move_speed;
  logic             r_adc_start;
  logic             r_adc_oe;
  logic             r_speed_valid;
  logic             r_busy;
  logic             r_timeout_err;
  logic             r_eoc_meta;
  logic             r_sync_q;
  logic             r_sync_qq;

  logic             w_tick;
  logic             w_eoc_rise;
  logic [ACC_W-1:0] w_sum;
  logic [7:0]       w_avg;
  logic [7:0]       w_shaped;

  // Two synchronizer flops plus one delay flop for the rising-edge detect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_eoc_meta <= 1'b0;
      r_sync_q   <= 1'b0;
      r_sync_qq  <= 1'b0;
    end else begin
      r_eoc_meta <= i_eoc;
      r_sync_q   <= r_eoc_meta;
      r_sync_qq  <= r_sync_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_period <= '0;
    end else if (r_period == PER_LAST) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  assign w_tick     = (r_period == PER_LAST);
  assign w_eoc_rise = r_sync_q & ~r_sync_qq;
  assign w_sum      = r_acc + ACC_W'(r_sample);
  assign w_avg      = 8'(w_sum >> AVG_LOG2);

  always_comb begin
`ifdef ADC_SPEED_DEADZONE_EN
    if (w_avg < 8'd16) begin
      w_shaped = 8'd0;
    end else if (w_avg > 8'd239) begin
      w_shaped = 8'hFF;
    end else begin
      w_shaped = w_avg;
    end
`else
    w_shaped = w_avg;
`endif
  end

  // Ticks seen outside IDLE are simply dropped; a new launch waits for the next wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_num         <= '0;
      r_sample      <= '0;
      r_move_speed  <= '0;
      r_adc_start   <= 1'b0;
      r_adc_oe      <= 1'b0;
      r_speed_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_speed_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick && i_enable) begin
            r_state     <= S_START;
            r_adc_start <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
          end
        end
        S_START: begin
          if (r_cnt == START_LAST) begin
            r_state     <= S_WAIT_EOC;
            r_adc_start <= 1'b0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_EOC: begin
          if (w_eoc_rise) begin
            r_state  <= S_READ;
            r_adc_oe <= 1'b1;
            r_cnt    <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (r_cnt == READ_LAST) begin
            r_sample <= i_adc_data;
            r_adc_oe <= 1'b0;
            r_state  <= S_ACCUM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          if (r_num == NUM_LAST) begin
            r_move_speed  <= w_shaped;
            r_speed_valid <= 1'b1;
            r_acc         <= '0;
            r_num         <= '0;
          end else begin
            r_acc <= w_sum;
            r_num <= r_num + 1'b1;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_adc_start <= 1'b0;
          r_adc_oe    <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_adc_start   = r_adc_start;
  assign o_adc_oe      = r_adc_oe;
  assign o_move_speed  = r_move_speed;
  assign o_speed_valid = r_speed_valid;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule
